// File: rtl/route_demux_1to5.sv
// Wormhole output-side steering stage: a head flit picks one of five directions
// (N/S/W/E/L), the choice is held until the tail, and a small FIFO absorbs backpressure.
module route_demux_1to5 #(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              head_i,
  input  logic              tail_i,
  input  logic [2:0]        dest_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [4:0]        valid_o,
  input  logic [4:0]        ready_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = DATA_W + 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUTE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [1:0]        state_q, state_d;
  logic [2:0]        dir_q, dir_d;
  logic              err_q, err_d;

  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              dest_ok;
  logic [2:0]        push_dir;
  logic [2:0]        head_dir;
  logic [DATA_W-1:0] head_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Input acceptance looks only at occupancy, never at ready_i.
  assign ready_o    = !rst_i && (count_q < CW'(FIFO_DEPTH));
  assign accept     = valid_i && ready_o;
  assign dest_ok    = (dest_i <= 3'd4);
  assign fifo_empty = (count_q == '0);

  assign head_dir  = mem_q[rd_ptr_q][2:0];
  assign head_data = mem_q[rd_ptr_q][EW-1:3];
  assign data_o    = fifo_empty ? '0 : head_data;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_valid
      assign valid_o[gi] = !fifo_empty && (head_dir == 3'(gi));
    end
  endgenerate

  assign pop    = |(valid_o & ready_i);
  assign busy_o = (state_q != ST_IDLE) || !fifo_empty;
  assign err_o  = err_q;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    err_d    = 1'b0;
    push     = 1'b0;
    push_dir = dir_q;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (head_i && dest_ok) begin
            push     = 1'b1;
            push_dir = dest_i;
            dir_d    = dest_i;
            if (!tail_i) state_d = ST_ROUTE;
          end else begin
            err_d = 1'b1;
            if (head_i && !tail_i) state_d = ST_DROP;
          end
        end
        ST_ROUTE: begin
          // A stray head mid-packet is flagged but still follows the locked direction.
          push = 1'b1;
          if (head_i) err_d = 1'b1;
          if (tail_i) state_d = ST_IDLE;
        end
        ST_DROP: begin
          if (tail_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      dir_q    <= 3'b000;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: stale entries are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {data_i, push_dir};
  end

endmodule

// File: tb/tb_route_demux_1to5.sv
// Bench for route_demux_1to5: directed scenarios plus random traffic, all checked
// against a packet-level queue model of the steering stage.
module tb_route_demux_1to5;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 2;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              valid_i = 1'b0;
  logic              ready_o;
  logic              head_i = 1'b0;
  logic              tail_i = 1'b0;
  logic [2:0]        dest_i = 3'd0;
  logic [DATA_W-1:0] data_i = '0;
  logic [DATA_W-1:0] data_o;
  logic [4:0]        valid_o;
  logic [4:0]        ready_i = 5'd0;
  logic              busy_o;
  logic              err_o;
  logic [11:0]       obs_vec;

  int errors = 0;
  int checks = 0;

  // Model: queue of {data, dir}, packet mode 0=idle 1=routing 2=dropping.
  logic [6:0] mq [$];
  int         m_mode = 0;
  logic [2:0] m_dir  = 3'd0;
  logic       m_err  = 1'b0;

  route_demux_1to5 #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .head_i(head_i), .tail_i(tail_i), .dest_i(dest_i), .data_i(data_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  assign obs_vec = {ready_o, valid_o, data_o, busy_o, err_o};

  function automatic logic [11:0] exp_vec();
    logic [4:0] v;
    logic [3:0] d;
    v = 5'd0;
    d = 4'd0;
    if (mq.size() > 0) begin
      v = 5'b00001 << mq[0][2:0];
      d = mq[0][6:3];
    end
    return {(!rst_i && mq.size() < DEPTH), v, d, (m_mode != 0 || mq.size() > 0), m_err};
  endfunction

  task automatic set_in(input logic v, input logic h, input logic t, input logic [2:0] d,
                        input logic [3:0] dat, input logic [4:0] r);
    valid_i = v; head_i = h; tail_i = t; dest_i = d; data_i = dat; ready_i = r;
  endtask

  // One clock: advance the model with the inputs the DUT sees at this edge.
  task automatic tick();
    logic acc;
    acc = valid_i && !rst_i && (mq.size() < DEPTH);
    @(posedge clk_i);
    if (rst_i) begin
      mq.delete();
      m_mode = 0;
      m_dir  = 3'd0;
      m_err  = 1'b0;
    end else begin
      m_err = 1'b0;
      if (mq.size() > 0 && ready_i[mq[0][2:0]]) void'(mq.pop_front());
      if (acc) begin
        if (m_mode == 0) begin
          if (!head_i) m_err = 1'b1;
          else if (dest_i > 3'd4) begin
            m_err = 1'b1;
            if (!tail_i) m_mode = 2;
          end else begin
            m_dir = dest_i;
            mq.push_back({data_i, dest_i});
            if (!tail_i) m_mode = 1;
          end
        end else if (m_mode == 1) begin
          if (head_i) m_err = 1'b1;
          mq.push_back({data_i, m_dir});
          if (tail_i) m_mode = 0;
        end else if (tail_i) begin
          m_mode = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 5'd0);
    tick();
    tick();
    checks++;
    if (obs_vec !== exp_vec())
      $display("FAIL reset_model obs=%h exp=%h", obs_vec, exp_vec());
    checks++;
    if ({valid_o, data_o, ready_o, busy_o} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outs valid=%b data=%h ready=%b busy=%b want all 0",
               valid_o, data_o, ready_o, busy_o);
    end
    if (obs_vec !== exp_vec()) errors++;
    rst_i = 1'b0;
    tick();
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release ready=%b want 1", ready_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    set_in(1'b1, 1'b1, 1'b1, 3'd3, 4'hA, 5'b01000);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 5'b01000);
    checks++;
    if (valid_o !== 5'b01000 || data_o !== 4'hA) begin
      errors++;
      $display("FAIL single_deliver valid=%b data=%h want 01000/a", valid_o, data_o);
    end
    tick();
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 5'd0 || obs_vec !== exp_vec()) begin
      errors++;
      $display("FAIL single_drain busy=%b valid=%b obs=%h exp=%h", busy_o, valid_o,
               obs_vec, exp_vec());
    end
    $display("test_single done");
  endtask

  task automatic test_fill();
    logic [3:0] got [$];
    logic [15:0] seq;
    logic acc;
    int idx;
    int cyc;
    for (idx = 0; idx < 2; idx++) begin
      set_in(1'b1, idx == 0, 1'b0, 3'd4, 4'(idx + 1), 5'd0);
      tick();
    end
    set_in(1'b1, 1'b0, 1'b0, 3'd4, 4'd3, 5'd0);
    checks++;
    if (ready_o !== 1'b0 || obs_vec !== exp_vec()) begin
      errors++;
      $display("FAIL fill_full ready=%b want 0 obs=%h exp=%h", ready_o, obs_vec, exp_vec());
    end
    ready_i = 5'b10000;
    cyc = 0;
    while ((idx < 4 || valid_o != 5'd0) && cyc < 20) begin
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++;
        $display("FAIL fill_cycle%0d obs=%h exp=%h", cyc, obs_vec, exp_vec());
      end
      if (valid_o[4]) got.push_back(data_o);
      acc = valid_i && ready_o;
      tick();
      if (acc) begin
        idx++;
        if (idx < 4) set_in(1'b1, 1'b0, idx == 3, 3'd4, 4'(idx + 1), 5'b10000);
        else valid_i = 1'b0;
      end
      cyc++;
    end
    seq = 16'd0;
    foreach (got[i]) seq = {seq[11:0], got[i]};
    checks++;
    if (got.size() != 4 || seq !== 16'h1234) begin
      errors++;
      $display("FAIL fill_sequence got %0d flits seq=%h want 4 flits 1234", got.size(), seq);
    end
    $display("test_fill done");
  endtask

  task automatic test_drop();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, i == 0, i == 3, (i == 0) ? 3'd6 : 3'd0, 4'(i + 5), 5'b11111);
      tick();
      checks++;
      if ({err_o, valid_o, ready_o} !== {i == 0, 5'd0, 1'b1}) begin
        errors++;
        $display("FAIL drop_flit%0d err=%b valid=%b ready=%b want err=%0d valid=0 ready=1",
                 i, err_o, valid_o, ready_o, i == 0);
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle busy=%b want 0", busy_o);
    end
    set_in(1'b1, 1'b1, 1'b1, 3'd0, 4'h7, 5'd0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 5'b11111);
    checks++;
    if (valid_o !== 5'b00001 || data_o !== 4'h7) begin
      errors++;
      $display("FAIL drop_recover valid=%b data=%h want 00001/7", valid_o, data_o);
    end
    tick();
    $display("test_drop done");
  endtask

  task automatic test_errors();
    set_in(1'b1, 1'b0, 1'b1, 3'd2, 4'h9, 5'd0);
    tick();
    checks++;
    if (err_o !== 1'b1 || valid_o !== 5'd0) begin
      errors++;
      $display("FAIL idle_body err=%b valid=%b want 1/00000", err_o, valid_o);
    end
    set_in(1'b1, 1'b1, 1'b0, 3'd2, 4'h3, 5'd0);
    tick();
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_one_cycle err=%b want 0", err_o);
    end
    set_in(1'b1, 1'b1, 1'b1, 3'd1, 4'h5, 5'd0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 5'b00100);
    checks++;
    if (err_o !== 1'b1 || obs_vec !== exp_vec()) begin
      errors++;
      $display("FAIL route_head err=%b want 1 obs=%h exp=%h", err_o, obs_vec, exp_vec());
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (valid_o !== 5'b00100 || data_o !== ((i == 0) ? 4'h3 : 4'h5)) begin
        errors++;
        $display("FAIL route_locked%0d valid=%b data=%h want 00100/%h", i, valid_o, data_o,
                 (i == 0) ? 4'h3 : 4'h5);
      end
      tick();
    end
    $display("test_errors done");
  endtask

  task automatic test_reset_mid();
    set_in(1'b1, 1'b1, 1'b0, 3'd1, 4'h1, 5'd0);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 3'd0, 4'h2, 5'd0);
    tick();
    valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++;
    if (valid_o !== 5'd0 || busy_o !== 1'b0 || data_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_flush valid=%b busy=%b data=%h want 0", valid_o, busy_o, data_o);
    end
    set_in(1'b1, 1'b0, 1'b0, 3'd0, 4'h4, 5'd0);
    tick();
    checks++;
    if (err_o !== 1'b1 || valid_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_body err=%b valid=%b want 1/00000", err_o, valid_o);
    end
    set_in(1'b1, 1'b1, 1'b1, 3'd2, 4'h6, 5'd0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 5'b11111);
    checks++;
    if (valid_o !== 5'b00100 || data_o !== 4'h6) begin
      errors++;
      $display("FAIL reset_mid_head valid=%b data=%h want 00100/6", valid_o, data_o);
    end
    tick();
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int bad = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst_i = ($urandom_range(0, 79) == 0);
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 99) < 35,
             $urandom_range(0, 99) < 35, 3'($urandom_range(0, 7)),
             4'($urandom), 5'($urandom));
      tick();
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cycle%0d obs=%h exp=%h (ready,valid,data,busy,err)",
                   cyc, obs_vec, exp_vec());
      end
    end
    rst_i = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drop();
    test_errors();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
